axis_packet_sink: RTL and testbench
===================================

# axis_packet_sink

AXI-Stream slave stage that sits directly downstream of the 32-bit stream master and consumes its beats. Accepted beats, with their `tlast` markers, are buffered in a DEPTH-entry FIFO and drained by a simple read port. The block counts completed packets and flags packets whose beat count differs from the expected `packet_size`. Backpressure reaches the master through `tready`.

## Interface

- `DATA_WIDTH`, 32: stream and read data width.
- `DEPTH`, 16: FIFO entries; must be a power of 2, minimum 2.
- `ADDR_WIDTH`, 4: log2(DEPTH).

- `clk`  in  1  single clock; all logic is on the rising edge.
- `resentn`  in  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is sampled on `clk`.
- `tdata`  in  DATA_WIDTH  stream payload.
- `tvalid`  in  1  payload valid.
- `tlast`  in  1  final beat of the packet.
- `tready`  out  1  sink can accept a beat.
- `packet_size`  in  4  expected beats per packet; 0 disables the check.
- `rd_en`  in  1  read request.
- `rd_data`  out  DATA_WIDTH  read payload.
- `rd_last`  out  1  `tlast` stored with `rd_data`.
- `rd_valid`  out  1  one-cycle pulse: `rd_data`/`rd_last` are valid.
- `empty`  out  1  FIFO holds 0 entries.
- `full`  out  1  FIFO holds DEPTH entries.
- `in_packet`  out  1  FSM is in IN_PKT.
- `pkt_count`  out  8  completed packets accepted; wraps 255→0.
- `len_err`  out  1  sticky length-mismatch flag.
- `err_clr`  in  1  synchronous clear of `len_err`.

## Operation

- FIFO entry is {tlast, tdata}, DATA_WIDTH+1 bits wide. Write pointer, read pointer and occupancy (ADDR_WIDTH+1 bits) are registers.
- `tready = !full`. Only the occupancy register drives it, so there is no combinational path from `tvalid`.
- Accept when `tvalid && tready`: store the entry, then advance the write pointer modulo DEPTH.
- Read when `rd_en && !empty`: the next cycle `rd_data`/`rd_last` hold the entry and `rd_valid`=1. `rd_en` while empty is ignored (`rd_valid`=0, pointers unchanged).
- Simultaneous accept and read leave occupancy unchanged. At full, `tready`=0, so a read frees a slot and `tready` rises the next cycle.
- FSM, two states:
  - IDLE→IN_PKT on accept with `tlast`=0.
  - IN_PKT→IDLE on accept with `tlast`=1.
  - An accept with `tlast`=1 in IDLE (a 1-beat packet) stays in IDLE.
- Beat counter, 5 bits:
  - Increments on each accept and saturates at 31.
  - Clears to 0 on an accept with `tlast`=1.
  - Packet length = beat counter + 1 at the `tlast` beat.
- On an accept with `tlast`=1, `pkt_count` increments.
- `tvalid` low mid-packet is legal. The FSM holds and the block applies no timeout.
- Reset mid-packet discards the FIFO contents and any partial packet.

## Timing

- Reset values: `tready`=1, `empty`=1, `full`=0, `rd_valid`=0, `rd_data`=0, `rd_last`=0, `in_packet`=0, `pkt_count`=0, `len_err`=0. FSM=IDLE, beat counter=0, pointers=0.
- Write-to-read latency: an entry accepted at edge N is readable with `rd_en` in cycle N+1, and `rd_valid` appears at N+2.
- `empty`/`full`/`tready` update the cycle after the accept or read that changes occupancy.
- Sustained throughput: 1 beat/cycle in and 1 beat/cycle out concurrently.
- `err_clr` has priority over a same-cycle error set: `len_err` reads 0 the next cycle.

## Configuration

- `AXIS_SINK_LEN_CHECK_EN` defined:
  - On a `tlast` accept with `packet_size`≠0 and packet length ≠ `packet_size` (zero-extended to 5 bits), `len_err` is set the next cycle.
  - `len_err` stays set until `err_clr` or reset.
- Undefined:
  - Beat counter and compare logic are removed.
  - `len_err` is tied to 0.
  - `packet_size` and `err_clr` are unused.
  - FSM and `pkt_count` are unaffected.

## Test plan

- Reset, then stream 4 beats 0xA0..0xA3 with `tlast` on 0xA3 and `packet_size`=4 → `pkt_count`=1, `len_err`=0. Read 4× → data in order, `rd_last`=1 only on 0xA3.
- Stream 16 beats with no reads → `full`=1 and `tready`=0 after the 16th accept; a 17th beat is held off. One read → `tready`=1 the next cycle and the held beat is accepted.
- `packet_size`=3, send a 5-beat packet → `len_err`=1 one cycle after `tlast` accept. Pulse `err_clr` → `len_err`=0. With the macro undefined, `len_err` stays 0.
- Concurrent `tvalid`=1 and `rd_en`=1 for 50 cycles at occupancy 8 → occupancy stays 8 and data order is preserved.
- Assert `resentn`=0 mid-packet with the FIFO holding 5 entries → all outputs return to reset values immediately, and `in_packet`=0.
- Send 256 one-beat packets → `pkt_count` wraps to 0, and `in_packet` never asserts.

Source files
------------

// File: rtl/axis_packet_sink.sv
// ---------------------------------------------------------------------------
// axis_packet_sink
//
// AXI-Stream slave that buffers accepted beats (payload plus tlast marker) in
// a DEPTH-entry FIFO, drained through a simple one-cycle-latency read port.
// It counts completed packets and can flag packets whose beat count differs
// from the expected packet_size.
//
// Optional feature (compile-time macro):
//   AXIS_SINK_LEN_CHECK_EN  - when defined, the beat counter and the length
//                             comparison are built and len_err is a sticky
//                             flag cleared by err_clr. When undefined, len_err
//                             is tied to 0 and packet_size/err_clr are unused.
//
// Ports:
//   clk          single clock, rising edge
//   resentn      asynchronous active-low reset (deassertion sampled on clk)
//   tdata        stream payload                     (DATA_WIDTH)
//   tvalid       stream payload valid
//   tlast        final beat of packet
//   tready       sink can accept a beat (driven only by the occupancy register)
//   packet_size  expected beats per packet, 0 disables the check (4)
//   rd_en        read request
//   rd_data      read payload                       (DATA_WIDTH)
//   rd_last      tlast stored with rd_data
//   rd_valid     one-cycle pulse, rd_data/rd_last valid
//   empty        FIFO holds no entries
//   full         FIFO holds DEPTH entries
//   in_packet    FSM is inside a multi-beat packet
//   pkt_count    completed packets accepted, wraps (8)
//   len_err      sticky length-mismatch flag
//   err_clr      synchronous clear of len_err (wins over a same-cycle set)
// ---------------------------------------------------------------------------
module axis_packet_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resentn,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tvalid,
    input  logic                  tlast,
    output logic                  tready,
    input  logic [3:0]            packet_size,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  in_packet,
    output logic [7:0]            pkt_count,
    output logic                  len_err,
    input  logic                  err_clr
);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    // Storage holds {tlast, tdata}; it carries no reset, only the pointers do.
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  accept;
    logic                  rd_fire;
    state_t                state;

    // Flags come straight from the occupancy register, so tready has no
    // combinational dependency on tvalid.
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign tready  = !full;
    assign accept  = tvalid && tready;
    assign rd_fire = rd_en && !empty;

    // ---- Stage 0: FIFO write and pointer/occupancy bookkeeping ----
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {tlast, tdata};
        end
    end

    always_ff @(posedge clk or negedge resentn) begin
        if (!resentn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer wrap is modulo DEPTH.
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---- Stage 1: registered read port ----
    always_ff @(posedge clk or negedge resentn) begin
        if (!resentn) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                {rd_last, rd_data} <= mem[rd_ptr];
            end
        end
    end

    // ---- Packet framing FSM and packet counter ----
    always_ff @(posedge clk or negedge resentn) begin
        if (!resentn) begin
            state     <= IDLE;
            in_packet <= 1'b0;
            pkt_count <= '0;
        end else if (accept) begin
            if (tlast) begin
                // A single-beat packet in IDLE simply stays in IDLE.
                state     <= IDLE;
                in_packet <= 1'b0;
                pkt_count <= pkt_count + 1'b1;
            end else begin
                state     <= IN_PKT;
                in_packet <= 1'b1;
            end
        end
    end

`ifdef AXIS_SINK_LEN_CHECK_EN
    // ---- Packet length check ----
    logic [4:0] beat_cnt;
    logic [5:0] pkt_len;
    logic       len_mismatch;

    // Length is evaluated on six bits so a saturated count of 31 (length 32)
    // never aliases onto a legal packet_size.
    assign pkt_len      = {1'b0, beat_cnt} + 6'd1;
    assign len_mismatch = accept && tlast && (packet_size != 4'd0) &&
                          (pkt_len != {2'b00, packet_size});

    always_ff @(posedge clk or negedge resentn) begin
        if (!resentn) begin
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            if (accept) begin
                if (tlast) begin
                    beat_cnt <= '0;
                end else if (beat_cnt != 5'd31) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            if (err_clr) begin
                len_err <= 1'b0;
            end else if (len_mismatch) begin
                len_err <= 1'b1;
            end
        end
    end
`else
    logic unused_len_inputs;

    assign unused_len_inputs = ^{packet_size, err_clr, state};
    assign len_err           = 1'b0;
`endif

endmodule

// File: tb/tb_axis_packet_sink.sv
// ---------------------------------------------------------------------------
// tb_axis_packet_sink
//
// Directed bench for axis_packet_sink. Every accepted beat pushes its
// expected {tlast, tdata} onto a queue; an independent monitor pops and
// compares whenever rd_valid is presented. Flag and counter values are
// checked against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_axis_packet_sink;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resentn;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic [3:0]    packet_size;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic          in_packet;
    logic [7:0]    pkt_count;
    logic          len_err;
    logic          err_clr;

    int            total = 0;
    int            bad   = 0;
    logic [DW:0]   exp_q[$];
    logic [DW:0]   mon_exp;
    logic          len_chk;

    always #5 clk = ~clk;

    axis_packet_sink #(
        .DATA_WIDTH(DW),
        .DEPTH     (16),
        .ADDR_WIDTH(4)
    ) dut (
        .clk        (clk),
        .resentn    (resentn),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tlast      (tlast),
        .tready     (tready),
        .packet_size(packet_size),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .in_packet  (in_packet),
        .pkt_count  (pkt_count),
        .len_err    (len_err),
        .err_clr    (err_clr)
    );

    // Read-side monitor: compares every presented read against the queue.
    always @(negedge clk) begin
        if (resentn && rd_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got %0h expected no read", {rd_last, rd_data});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({rd_last, rd_data} !== mon_exp) begin
                    bad++;
                    $display("FAIL rd_data: got %0h expected %0h", {rd_last, rd_data}, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int guard = 0;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        while (!tready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!tready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got tready=0 expected 1");
            tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back({l, d});
        #1;
        tvalid = 1'b0;
    endtask

    task automatic read_n(input int n);
        rd_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef AXIS_SINK_LEN_CHECK_EN
        len_chk = 1'b1;
`else
        len_chk = 1'b0;
`endif
        resentn     = 1'b0;
        tdata       = '0;
        tvalid      = 1'b0;
        tlast       = 1'b0;
        packet_size = 4'd0;
        rd_en       = 1'b0;
        err_clr     = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        check("rst_tready", 32'(tready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_in_packet", 32'(in_packet), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        resentn = 1'b1;
        @(posedge clk);
        #1;

        // Four-beat packet of the expected size
        packet_size = 4'd4;
        send_beat(32'hA0, 1'b0);
        check("t1_in_packet", 32'(in_packet), 32'd1);
        check("t1_empty", 32'(empty), 32'd0);
        send_beat(32'hA1, 1'b0);
        send_beat(32'hA2, 1'b0);
        send_beat(32'hA3, 1'b1);
        check("t1_pkt_count", 32'(pkt_count), 32'd1);
        check("t1_in_packet_end", 32'(in_packet), 32'd0);
        check("t1_len_err", 32'(len_err), 32'd0);
        read_n(4);
        check("t1_empty_after", 32'(empty), 32'd1);

        // Reads while empty are ignored
        rd_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rd_en = 1'b0;
        check("empty_read_valid", 32'(rd_valid), 32'd0);
        check("empty_read_empty", 32'(empty), 32'd1);

        // Fill to full, hold off a 17th beat, free one slot
        packet_size = 4'd0;
        for (int i = 0; i < 16; i++) send_beat(32'hB00 + 32'(i), 1'b0);
        check("t2_full", 32'(full), 32'd1);
        check("t2_tready", 32'(tready), 32'd0);
        tdata  = 32'hB10;
        tlast  = 1'b1;
        tvalid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("t2_held", 32'(tready), 32'd0);
        end
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check("t2_tready_rise", 32'(tready), 32'd1);
        check("t2_full_drop", 32'(full), 32'd0);
        @(posedge clk);
        exp_q.push_back({1'b1, 32'hB10});
        #1;
        tvalid = 1'b0;
        check("t2_full_again", 32'(full), 32'd1);
        check("t2_pkt_count", 32'(pkt_count), 32'd2);
        read_n(16);
        check("t2_empty", 32'(empty), 32'd1);

        // Length check: 5 beats against packet_size 3
        packet_size = 4'd3;
        for (int i = 0; i < 4; i++) send_beat(32'hC0 + 32'(i), 1'b0);
        send_beat(32'hC4, 1'b1);
        check("t3_len_err_set", 32'(len_err), 32'(len_chk));
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("t3_len_err_clr", 32'(len_err), 32'd0);
        for (int i = 0; i < 2; i++) send_beat(32'hD0 + 32'(i), 1'b0);
        send_beat(32'hD2, 1'b1);
        check("t3_len_ok", 32'(len_err), 32'd0);
        // Clear wins over a same-cycle set on a 2-beat packet
        err_clr = 1'b1;
        send_beat(32'hE0, 1'b0);
        send_beat(32'hE1, 1'b1);
        err_clr = 1'b0;
        check("t3_clr_priority", 32'(len_err), 32'd0);
        // packet_size 0 disables the check
        packet_size = 4'd0;
        send_beat(32'hF0, 1'b0);
        send_beat(32'hF1, 1'b1);
        check("t3_size0", 32'(len_err), 32'd0);
        check("t3_pkt_count", 32'(pkt_count), 32'd6);
        read_n(12);

        // Concurrent write and read at occupancy 8
        for (int i = 0; i < 8; i++) send_beat(32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 50; i++) begin
            tdata  = 32'h200 + 32'(i);
            tlast  = 1'b0;
            tvalid = 1'b1;
            rd_en  = 1'b1;
            check("t4_tready", 32'(tready), 32'd1);
            @(posedge clk);
            exp_q.push_back({1'b0, 32'h200 + 32'(i)});
            #1;
            check("t4_flags", {30'd0, full, empty}, 32'd0);
        end
        tvalid = 1'b0;
        rd_en  = 1'b0;
        read_n(7);
        check("t4_not_empty_at_1", 32'(empty), 32'd0);
        read_n(1);
        check("t4_empty_at_8", 32'(empty), 32'd1);
        check("t4_in_packet", 32'(in_packet), 32'd1);
        send_beat(32'h300, 1'b1);
        read_n(1);

        // Asynchronous reset mid-packet with 5 entries held
        for (int i = 0; i < 5; i++) send_beat(32'h400 + 32'(i), 1'b0);
        check("t5_in_packet_pre", 32'(in_packet), 32'd1);
        #2;
        resentn = 1'b0;
        #1;
        exp_q.delete();
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_tready", 32'(tready), 32'd1);
        check("t5_full", 32'(full), 32'd0);
        check("t5_in_packet", 32'(in_packet), 32'd0);
        check("t5_pkt_count", 32'(pkt_count), 32'd0);
        check("t5_rd_data", rd_data, 32'd0);
        check("t5_rd_last", 32'(rd_last), 32'd0);
        check("t5_rd_valid", 32'(rd_valid), 32'd0);
        check("t5_len_err", 32'(len_err), 32'd0);
        @(posedge clk);
        #1;
        resentn = 1'b1;
        @(posedge clk);
        #1;

        // 256 one-beat packets with a concurrent drain
        for (int i = 0; i < 256; i++) begin
            tdata  = 32'h500 + 32'(i);
            tlast  = 1'b1;
            tvalid = 1'b1;
            rd_en  = (i > 0);
            @(posedge clk);
            exp_q.push_back({1'b1, 32'h500 + 32'(i)});
            #1;
            check("t6_in_packet", 32'(in_packet), 32'd0);
            check("t6_pkt_count", 32'(pkt_count), 32'((i + 1) % 256));
        end
        tvalid = 1'b0;
        rd_en  = 1'b0;
        read_n(1);
        check("t6_wrap", 32'(pkt_count), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);

        @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
